mul64_seq: RTL and testbench



---
 rtl/mul_pkg.sv | 22 ++
 rtl/addsub64bit.sv | 29 ++
 rtl/mul64_seq.sv | 114 +++++++++++
 tb/tb_mul64_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and sizes for the iterative 64-bit multiplier.
//               MUL_W - operand / result width
//               CNT_W - iteration counter width (covers 0..MUL_W-1)
//               state_e - controller states
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_W = 64;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/addsub64bit.sv
`default_nettype none
// ============================================================================
// Module      : addsub64bit
// Description : 64-bit two's complement adder-subtractor.
//               in1, in2 - operands
//               op       - 0: out = in1 + in2, 1: out = in1 - in2
//               out      - 64-bit result (carry out discarded)
//               OF_FLAG  - signed overflow of the selected operation
// Revision    : 1.0 - initial release
// ============================================================================
module addsub64bit (
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    input  logic        op,
    output logic [63:0] out,
    output logic        OF_FLAG
);

    logic [63:0] in2_eff;

    // Subtraction as in1 + ~in2 + 1.
    assign in2_eff = op ? ~in2 : in2;
    assign out     = in1 + in2_eff + {63'd0, op};

    // Overflow when both effective operands share a sign that the sum lacks.
    assign OF_FLAG = (in1[63] == in2_eff[63]) && (out[63] != in1[63]);

endmodule : addsub64bit
`default_nettype wire

// File: rtl/mul64_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul64_seq
// Description : Iterative shift-add multiplier producing (a*b) mod 2^64 by
//               sequencing one addsub64bit in add mode, one bit per cycle.
//   EARLY_EXIT  - 1: stop once no multiplier bits remain; 0: always 64 steps
//   clk         - clock, rising edge
//   rst_n       - synchronous active-low reset
//   start_valid - operands a/b presented      start_ready - can accept
//   a, b        - multiplicand / multiplier
//   res_valid   - result valid                res_ready   - result taken
//   result      - low 64 bits of the product
//   busy        - operation in RUN or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module mul64_seq
    import mul_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [MUL_W-1:0] result,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [MUL_W-1:0]   acc_q, acc_d;
    logic [MUL_W-1:0]   mcand_q, mcand_d;
    logic [MUL_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MUL_W-1:0]   sum;
    logic               of_flag_unused;

    // Shared adder: acc + mcand, overflow intentionally not used.
    addsub64bit u_addsub (
        .in1     (acc_q),
        .in2     (mcand_q),
        .op      (1'b0),
        .out     (sum),
        .OF_FLAG (of_flag_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // mplier_d is the multiplier after this step's shift: once it
                // is zero no further additions can change acc.
                if ((cnt_q == CNT_W'(MUL_W - 1)) ||
                    (EARLY_EXIT && (mplier_d == '0))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode from registered state only.
    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign result      = acc_q;

endmodule : mul64_seq
`default_nettype wire

// File: tb/tb_mul64_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul64_seq
// Description : Self-checking bench for mul64_seq, with one instance using
//               early exit (index 1) and one running all 64 steps (index 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul64_seq;

    logic        clk;
    logic        rst_n;
    logic        sv  [2];
    logic        rr  [2];
    logic [63:0] a_in[2];
    logic [63:0] b_in[2];
    logic        sr  [2];
    logic        rv  [2];
    logic [63:0] res [2];
    logic        bz  [2];

    int checks = 0;
    int errors = 0;

    mul64_seq #(.EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv[0]), .start_ready(sr[0]),
        .a(a_in[0]), .b(b_in[0]),
        .res_valid(rv[0]), .res_ready(rr[0]),
        .result(res[0]), .busy(bz[0])
    );

    mul64_seq #(.EARLY_EXIT(1'b1)) dut_early (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv[1]), .start_ready(sr[1]),
        .a(a_in[1]), .b(b_in[1]),
        .res_valid(rv[1]), .res_ready(rr[1]),
        .result(res[1]), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        int          lat_early;   // cycles from accept to first res_valid
    } vec_t;

    localparam int NV = 9;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation on instance sel with res_ready already high and
    // return the result and the latency observed at the first res_valid.
    task automatic run_op(input int sel, input logic [63:0] av, input logic [63:0] bv,
                          output logic [63:0] r, output int lat);
        @(negedge clk);
        rr[sel]   = 1'b1;
        sv[sel]   = 1'b1;
        a_in[sel] = av;
        b_in[sel] = bv;
        @(posedge clk);
        #1;
        sv[sel]   = 1'b0;
        a_in[sel] = '0;
        b_in[sel] = '0;
        lat = 0;
        r   = '0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (rv[sel]) begin
                r = res[sel];
                break;
            end
        end
    endtask

    initial begin
        logic [63:0] r;
        int          lat;
        bit          stale;

        vt[0] = '{64'd3, 64'd5, 64'd15, 4};
        vt[1] = '{64'h1234, 64'd0, 64'd0, 2};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65};
        vt[3] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 3};
        vt[4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6, 4};
        vt[5] = '{64'd4, 64'd4, 64'd16, 4};
        vt[6] = '{64'hDEAD_BEEF, 64'h100, 64'h00DE_ADBE_EF00, 10};
        vt[7] = '{64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65};
        vt[8] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 34};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; rr[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset start_ready", {63'd0, sr[i]}, 64'd1);
            chk("reset res_valid",   {63'd0, rv[i]}, 64'd0);
            chk("reset result",      res[i],         64'd0);
            chk("reset busy",        {63'd0, bz[i]}, 64'd0);
        end
        rst_n = 1'b1;

        // Table: both instances, early-exit and fixed 64-step latency.
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < NV; v++) begin
                run_op(s, vt[v].a, vt[v].b, r, lat);
                chk($sformatf("result s%0d v%0d", s, v), r, vt[v].r);
                chk($sformatf("latency s%0d v%0d", s, v), 64'(lat),
                    64'((s == 1) ? vt[v].lat_early : 65));
                @(negedge clk);
                chk($sformatf("ready after s%0d v%0d", s, v), {63'd0, sr[s]}, 64'd1);
            end
        end

        // Backpressure: result held, new operands refused while in DONE.
        @(negedge clk);
        rr[1] = 1'b0;
        sv[1] = 1'b1; a_in[1] = 64'd3; b_in[1] = 64'd5;
        @(posedge clk);
        #1;
        sv[1] = 1'b0;
        lat = 0;
        while (!rv[1] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", 64'(lat), 64'd4);
        for (int c = 0; c < 10; c++) begin
            sv[1]   = ~sv[1];
            a_in[1] = 64'(c + 100);
            b_in[1] = 64'(c + 7);
            @(negedge clk);
            chk("bp result held", res[1], 64'd15);
            chk("bp start_ready", {63'd0, sr[1]}, 64'd0);
            chk("bp res_valid",   {63'd0, rv[1]}, 64'd1);
        end
        sv[1] = 1'b0;
        rr[1] = 1'b1;
        @(negedge clk);
        chk("bp idle res_valid", {63'd0, rv[1]}, 64'd0);
        chk("bp idle ready",     {63'd0, sr[1]}, 64'd1);
        chk("bp idle busy",      {63'd0, bz[1]}, 64'd0);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        sv[1] = 1'b1; a_in[1] = 64'd9; b_in[1] = 64'hFF;
        @(posedge clk);
        #1;
        sv[1] = 1'b0;
        @(negedge clk);       // T+1
        @(negedge clk);       // T+2
        @(negedge clk);       // T+3
        chk("mid-run busy", {63'd0, bz[1]}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("post-rst busy",      {63'd0, bz[1]}, 64'd0);
        chk("post-rst res_valid", {63'd0, rv[1]}, 64'd0);
        chk("post-rst result",    res[1],         64'd0);
        chk("post-rst ready",     {63'd0, sr[1]}, 64'd1);
        stale = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rv[1] || bz[1]) stale = 1'b1;
        end
        chk("no stale result", {63'd0, stale}, 64'd0);
        run_op(1, 64'd4, 64'd4, r, lat);
        chk("fresh 4*4", r, 64'd16);
        chk("fresh 4*4 latency", 64'(lat), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul64_seq
`default_nettype wire
